// File: rtl/mdu_if.sv
// Handshake and result bundle between the EX-stage issue logic and the multiply/divide unit.
interface mdu_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        cancel;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start,
      output op,
      output A,
      output B,
      output cancel,
      input  busy,
      input  HI,
      input  LO
   );

   modport slave (
      input  start,
      input  op,
      input  A,
      input  B,
      input  cancel,
      output busy,
      output HI,
      output LO
   );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: owns HI/LO, computes the 64-bit result at issue
// and holds it in a pending register while busy models the multi-cycle latency.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic               pend_wr_q, pend_wr_d;

   logic [63:0] mul_s;
   logic [63:0] mul_u;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [31:0] sdiv_den;
   logic [31:0] udiv_den;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] sdiv_q;
   logic [31:0] sdiv_r;
   logic [31:0] udiv_q;
   logic [31:0] udiv_r;
   logic        issue;

   // Only an uncancelled start seen while idle does anything.
   assign issue = bus.start && !bus.cancel && (state_q == IDLE);

   // Signed product by sign-extending both operands; the low 64 bits are exact.
   assign mul_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
   assign mul_u = {32'd0, bus.A} * {32'd0, bus.B};

   // Signed divide done on magnitudes, then the quotient takes the xor of the signs and
   // the remainder the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0.
   // A zero divisor is swapped for 1 only to keep the datapath defined; that result is never committed.
   assign abs_a    = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
   assign abs_b    = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
   assign sdiv_den = (abs_b == 32'd0) ? 32'd1 : abs_b;
   assign udiv_den = (bus.B == 32'd0) ? 32'd1 : bus.B;
   assign q_mag    = abs_a / sdiv_den;
   assign r_mag    = abs_a % sdiv_den;
   assign sdiv_q   = (bus.A[31] ^ bus.B[31]) ? (~q_mag + 32'd1) : q_mag;
   assign sdiv_r   = bus.A[31] ? (~r_mag + 32'd1) : r_mag;
   assign udiv_q   = bus.A / udiv_den;
   assign udiv_r   = bus.A % udiv_den;

   // Next-state logic: issue from IDLE, count down in RUN, commit the pending result on the last cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      case (state_q)
         IDLE: begin
            if (issue) begin
               case (bus.op)
                  OP_MULT: begin
                     pend_hi_d = mul_s[63:32];
                     pend_lo_d = mul_s[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     busy_d    = 1'b1;
                     state_d   = RUN;
                  end
                  OP_MULTU: begin
                     pend_hi_d = mul_u[63:32];
                     pend_lo_d = mul_u[31:0];
                     pend_wr_d = 1'b1;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     busy_d    = 1'b1;
                     state_d   = RUN;
                  end
                  OP_DIV: begin
                     pend_hi_d = sdiv_r;
                     pend_lo_d = sdiv_q;
                     pend_wr_d = (bus.B != 32'd0);
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     busy_d    = 1'b1;
                     state_d   = RUN;
                  end
                  OP_DIVU: begin
                     pend_hi_d = udiv_r;
                     pend_lo_d = udiv_q;
                     pend_wr_d = (bus.B != 32'd0);
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     busy_d    = 1'b1;
                     state_d   = RUN;
                  end
                  OP_MTHI: begin
                     hi_d = bus.A;
                  end
                  OP_MTLO: begin
                     lo_d = bus.A;
                  end
                  default: begin
                  end
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State and architectural registers; reset discards any in-flight result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a table of operations with expected HI/LO/latency fed through a
// scoreboard queue, randomised operations checked against a behavioural model, and hand-written
// sequences for reset, cancel, start-while-busy and back-to-back issue.
module tb_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_NOP   = 3'd6;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
      int          expCycles;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   mdu_if bus();

   mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t sbQ[$];
   vec_t vecs[13];
   int   vecCount  = 0;
   int   missCount = 0;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
      vecCount++;
      if (act !== req) begin
         missCount++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic pushExpect(input string name, input logic [31:0] hi, input logic [31:0] lo,
                             input int cycles);
      exp_t e;
      e.name   = name;
      e.hi     = hi;
      e.lo     = lo;
      e.cycles = cycles;
      sbQ.push_back(e);
   endtask

   // Drives one issue cycle and records the expected outcome; returns at the negedge after the issue edge.
   task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic cancel, input logic [31:0] expHi,
                                input logic [31:0] expLo, input int expCycles);
      pushExpect(name, expHi, expLo, expCycles);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.A      = a;
      bus.B      = b;
      bus.cancel = cancel;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      bus.op     = OP_NOP;
   endtask

   // Counts negedges with busy high, bounded so a stuck busy becomes a miscompare.
   task automatic waitBusyLow(output int cycles);
      cycles = 0;
      while (bus.busy === 1'b1 && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic checkOutput(input int cycles);
      exp_t e;
      if (sbQ.size() == 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL scoreboard-empty: actual=0 entries required=1");
      end else begin
         e = sbQ.pop_front();
         checkVal({e.name, " busy-cycles"}, 32'(cycles), 32'(e.cycles));
         checkVal({e.name, " busy"}, {31'd0, bus.busy}, 32'd0);
         checkVal({e.name, " HI"}, bus.HI, e.hi);
         checkVal({e.name, " LO"}, bus.LO, e.lo);
      end
   endtask

   task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                        input int expCycles);
      int c;
      applyStimulus(name, op, a, b, 1'b0, expHi, expLo, expCycles);
      waitBusyLow(c);
      checkOutput(c);
   endtask

   // Behavioural model using native SV signed/unsigned arithmetic.
   function automatic void modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
      longint      sp;
      logic [63:0] up;
      int          sa;
      int          sb;
      sa = a;
      sb = b;
      hi = 32'd0;
      lo = 32'd0;
      case (op)
         OP_MULT: begin
            sp = longint'(sa) * longint'(sb);
            hi = sp[63:32];
            lo = sp[31:0];
         end
         OP_MULTU: begin
            up = 64'(a) * 64'(b);
            hi = up[63:32];
            lo = up[31:0];
         end
         OP_DIV: begin
            lo = sa / sb;
            hi = sa % sb;
         end
         default: begin
            lo = a / b;
            hi = a % b;
         end
      endcase
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          c;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] rhi;
      logic [31:0] rlo;

      bus.start  = 1'b0;
      bus.op     = OP_NOP;
      bus.A      = 32'd0;
      bus.B      = 32'd0;
      bus.cancel = 1'b0;

      vecs[0]  = '{"mult -2*3",        OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MULT_N};
      vecs[1]  = '{"multu -2*3",       OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, MULT_N};
      vecs[2]  = '{"div -7/2",         OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
      vecs[3]  = '{"divu 7/2",         OP_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, DIV_N};
      vecs[4]  = '{"mthi",             OP_MTHI,  32'hAAAA0000, 32'd0,        32'hAAAA0000, 32'h00000003, 0};
      vecs[5]  = '{"mtlo",             OP_MTLO,  32'h00005555, 32'd0,        32'hAAAA0000, 32'h00005555, 0};
      vecs[6]  = '{"div by zero",      OP_DIV,   32'h00001234, 32'd0,        32'hAAAA0000, 32'h00005555, DIV_N};
      vecs[7]  = '{"divu by zero",     OP_DIVU,  32'd5,        32'd0,        32'hAAAA0000, 32'h00005555, DIV_N};
      vecs[8]  = '{"div overflow",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_N};
      vecs[9]  = '{"mult min*min",     OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_N};
      vecs[10] = '{"multu max*max",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULT_N};
      vecs[11] = '{"div 7/-2",         OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_N};
      vecs[12] = '{"nop op6",          OP_NOP,   32'h12345678, 32'd9,        32'h00000001, 32'hFFFFFFFD, 0};

      // Reset state
      repeat (2) @(negedge clk);
      checkVal("reset busy", {31'd0, bus.busy}, 32'd0);
      checkVal("reset HI", bus.HI, 32'd0);
      checkVal("reset LO", bus.LO, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].expHi, vecs[i].expLo, vecs[i].expCycles);
      end

      for (int i = 0; i < 6; i++) begin
         rop = 3'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (rb == 32'd0) rb = 32'd1;
         if (rop == OP_DIV && ra == 32'h80000000) ra = 32'd1;
         modelOp(rop, ra, rb, rhi, rlo);
         runOp("random op", rop, ra, rb, rhi, rlo,
               (rop == OP_MULT || rop == OP_MULTU) ? MULT_N : DIV_N);
      end

      // Back-to-back: DIVU issued on the first busy-low cycle after a MULT
      runOp("b2b mult", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, MULT_N);
      pushExpect("b2b divu", 32'd2, 32'd14, DIV_N);
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.A     = 32'd100;
      bus.B     = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NOP;
      checkVal("b2b second accepted", {31'd0, bus.busy}, 32'd1);
      checkVal("b2b HI held during run", bus.HI, 32'd0);
      waitBusyLow(c);
      checkOutput(c);

      // Start while busy must be ignored
      applyStimulus("busy mult", OP_MULT, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42, MULT_N);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MTHI;
      bus.A     = 32'h0000DEAD;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NOP;
      checkVal("busy mthi ignored HI", bus.HI, 32'd2);
      waitBusyLow(c);
      checkOutput(c + 2);

      // Cancel blocks issue
      applyStimulus("cancel mult", OP_MULT, 32'd5, 32'd5, 1'b1, 32'd0, 32'd42, 0);
      waitBusyLow(c);
      checkOutput(c);
      applyStimulus("cancel mthi", OP_MTHI, 32'h0000FFFF, 32'd0, 1'b1, 32'd0, 32'd42, 0);
      waitBusyLow(c);
      checkOutput(c);

      // Asynchronous reset in the middle of a DIV
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.A     = 32'd100;
      bus.B     = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = OP_NOP;
      repeat (3) @(negedge clk);
      checkVal("pre-reset busy", {31'd0, bus.busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      checkVal("mid-run reset busy", {31'd0, bus.busy}, 32'd0);
      checkVal("mid-run reset HI", bus.HI, 32'd0);
      checkVal("mid-run reset LO", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      runOp("mtlo after reset", OP_MTLO, 32'h00001234, 32'd0, 32'd0, 32'h00001234, 0);
      repeat (DIV_N + 2) @(negedge clk);
      checkVal("discarded div busy", {31'd0, bus.busy}, 32'd0);
      checkVal("discarded div HI", bus.HI, 32'd0);
      checkVal("discarded div LO", bus.LO, 32'h00001234);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the two register-file read operands, forwarded and carried through ID/EX.
- Holds the architectural HI/LO registers and models multi-cycle latency with a busy flag; hazard control uses that flag to stall dependent md-class instructions.
- HI/LO values feed mfhi/mflo, which reach the register-file write port through MEM/WB.

Parameters:
- MULT_CYCLES, 5: busy duration of mult/multu in cycles (>=1).
- DIV_CYCLES, 10: busy duration of div/divu in cycles (>=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  issue strobe for the operation in op; sampled on rising edge.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6-7=no-op.
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
- B  input  32  operand rt (divisor / multiplier).
- cancel  input  1  exception/interrupt flush of the EX instruction; blocks issue this cycle.
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0, FSM=IDLE.
  - Any pending result is discarded.
  - Deassertion takes effect on the next rising clk edge.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1; counter counts down.
- Issue from IDLE at a rising edge with start=1, cancel=0:
  - MULT/MULTU/DIV/DIVU: compute the 64-bit result from A/B at issue and latch it into internal pend_hi/pend_lo. Load counter=MULT_CYCLES or DIV_CYCLES, go to RUN. busy rises in the cycle after the issue edge.
  - MTHI: HI<=A at that edge. LO unchanged, no busy, stay IDLE.
  - MTLO: LO<=A at that edge. HI unchanged, no busy, stay IDLE.
  - op 6-7: no effect.
- RUN state:
  - Counter decrements each edge.
  - At the edge where the counter reaches 0: HI<=pend_hi, LO<=pend_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles; the new HI/LO are visible in the first cycle busy is low.
  - Back-to-back issue is allowed on that first busy-low cycle.
- start while busy=1: ignored entirely. Upstream stall logic prevents it; bench checks no corruption.
- cancel=1 with start=1: no state change. HI/LO and busy are unaffected. This keeps HI/LO precise for the flushed instruction.
- cancel does not abort an operation already in RUN; the committed older instruction completes.
- While in RUN, HI/LO outputs hold their old values. mfhi/mflo must stall on busy; this is hazard unit responsibility.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: unsigned 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
  - DIV: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient to LO, remainder to HI.
  - Divide by zero (B=0, DIV or DIVU): operation still runs DIV_CYCLES with busy=1, but HI/LO are left unchanged at completion.
- Outputs HI, LO, busy are registered. No combinational path from inputs to outputs.

Test Plan:
1. Reset: drive reset=0 mid-RUN of a DIV -> busy=0, HI=LO=0 immediately; after release, issue MTLO A=0x1234 -> LO=0x00001234 next cycle, HI=0.
2. MULT: A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. DIV: A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
4. Divide by zero and overflow:
   - Preload HI=0xAAAA0000, LO=0x5555 via MTHI/MTLO; DIV B=0 -> busy 10 cycles, HI/LO unchanged.
   - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. cancel and start-while-busy:
   - start=1, cancel=1, MULT -> busy stays 0, HI/LO unchanged.
   - During RUN, pulse start with MTHI A=0xDEAD -> ignored; final HI is the mult result.
6. Back-to-back: issue MULT, then issue DIVU on the first cycle busy=0 -> second op accepted; busy low for exactly one cycle between the two runs; final HI/LO are the DIVU result.
